// File: rtl/simon_sched_pkg.sv
// Shared types and default parameters for the SIMON request scheduler.
// The state encoding mirrors the scheduler's operation sequence.
package simon_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    KEY_WR,
    KEY_GAP,
    START,
    WAIT,
    RESP
  } state_e;

  localparam logic [8:0] DEF_KEY_BASE  = 9'h010;
  localparam int         DEF_KEY_WORDS = 2;
  localparam int         DEF_TIMEOUT   = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
// Returns the first request at or after ptr_i, wrapping past the top index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int PW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [PW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [PW-1:0]      idx_o,
  output logic               any_o
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand = PW'((int'(ptr_i) + off) % NUM_REQ);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/simon_req_sched.sv
// Round-robin scheduler sharing one simonrngtop among NUM_REQ clients.
// Optionally rekeys from the RNG, runs one encryption, returns the ciphertext.
module simon_req_sched
  import simon_sched_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter logic [8:0] KEY_BASE  = DEF_KEY_BASE,
  parameter int         KEY_WORDS = DEF_KEY_WORDS,
  parameter int         TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_rekey,
  input  logic [NUM_REQ*32-1:0] req_pt,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [31:0]           rsp_data,
  output logic                  rsp_error,
  output logic                  busy,
  output logic                  key_we,
  output logic [8:0]            key_addr,
  input  logic                  key_ack,
  output logic                  cipher_en,
  output logic [31:0]           plaintext,
  input  logic [31:0]           cipher_out,
  input  logic                  done
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [1:0] LAST_WORD = 2'(KEY_WORDS - 1);

  state_e               state_q;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic                 key_loaded_q;
  logic [TW-1:0]        timer_q;
  logic [1:0]           word_q;
  logic [NUM_REQ-1:0]   winner_q;
  logic [31:0]          pt_q;
  logic                 do_key_q;

  logic [NUM_REQ-1:0]   req_ready_q, rsp_valid_q;
  logic [31:0]          rsp_data_q, plaintext_q;
  logic                 rsp_error_q, busy_q, key_we_q, cipher_en_q;
  logic [8:0]           key_addr_q;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [PW-1:0]        arb_idx;
  logic                 arb_any;
  logic                 timed_out;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i (req_valid),
    .ptr_i (rr_ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  assign rr_ptr_d  = (arb_idx == PW'(NUM_REQ - 1)) ? '0 : arb_idx + PW'(1);
  assign timed_out = (timer_q == TW'(TIMEOUT - 1));

  // Outputs are registered and set on the transition into the state that owns them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      key_loaded_q <= 1'b0;
      timer_q      <= '0;
      word_q       <= '0;
      winner_q     <= '0;
      pt_q         <= '0;
      do_key_q     <= 1'b0;
      req_ready_q  <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
      busy_q       <= 1'b0;
      key_we_q     <= 1'b0;
      key_addr_q   <= '0;
      cipher_en_q  <= 1'b0;
      plaintext_q  <= '0;
    end else begin
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      cipher_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (arb_any) begin
            state_q     <= GRANT;
            busy_q      <= 1'b1;
            req_ready_q <= arb_gnt;
            winner_q    <= arb_gnt;
            pt_q        <= req_pt[32*arb_idx +: 32];
            do_key_q    <= req_rekey[arb_idx] | ~key_loaded_q;
            rr_ptr_q    <= rr_ptr_d;
          end
        end
        GRANT: begin
          if (do_key_q) begin
            state_q    <= KEY_WR;
            key_we_q   <= 1'b1;
            key_addr_q <= KEY_BASE;
            word_q     <= '0;
            timer_q    <= '0;
          end else begin
            state_q     <= START;
            cipher_en_q <= 1'b1;
            plaintext_q <= pt_q;
          end
        end
        KEY_WR: begin
          if (key_ack) begin
            key_we_q <= 1'b0;
            state_q  <= KEY_GAP;
          end else if (timed_out) begin
            key_we_q     <= 1'b0;
            key_loaded_q <= 1'b0;
            rsp_error_q  <= 1'b1;
            rsp_data_q   <= '0;
            rsp_valid_q  <= winner_q;
            state_q      <= RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        KEY_GAP: begin
          if (word_q == LAST_WORD) begin
            key_loaded_q <= 1'b1;
            state_q      <= START;
            cipher_en_q  <= 1'b1;
            plaintext_q  <= pt_q;
          end else begin
            word_q     <= word_q + 2'd1;
            key_addr_q <= KEY_BASE + 9'(word_q) + 9'd1;
            key_we_q   <= 1'b1;
            timer_q    <= '0;
            state_q    <= KEY_WR;
          end
        end
        START: begin
          // done seen on this edge belongs to a previous run and is ignored
          state_q <= WAIT;
          timer_q <= '0;
        end
        WAIT: begin
          if (done) begin
            rsp_data_q  <= cipher_out;
            rsp_error_q <= 1'b0;
            rsp_valid_q <= winner_q;
            state_q     <= RESP;
          end else if (timed_out) begin
            key_loaded_q <= 1'b0;
            rsp_error_q  <= 1'b1;
            rsp_data_q   <= '0;
            rsp_valid_q  <= winner_q;
            state_q      <= RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RESP: begin
          rsp_error_q <= 1'b0;
          rsp_data_q  <= '0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_error = rsp_error_q;
  assign busy      = busy_q;
  assign key_we    = key_we_q;
  assign key_addr  = key_addr_q;
  assign cipher_en = cipher_en_q;
  assign plaintext = plaintext_q;

endmodule

// File: tb/tb_simon_req_sched.sv
// Directed bench for simon_req_sched: a table of request transactions against a
// small simonrngtop responder, plus hand-written reset-abort sequence.
module tb_simon_req_sched;

  localparam int         NUM_REQ   = 4;
  localparam int         KEY_WORDS = 2;
  localparam logic [8:0] KEY_BASE  = 9'h010;
  localparam int         TIMEOUT   = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   reqValid, reqRekey;
  logic [127:0] reqPt;
  logic [3:0]   reqReady, rspValid;
  logic [31:0]  rspData, plaintext, cipherOut;
  logic         rspError, busy, keyWe, keyAck, cipherEn, done;
  logic [8:0]   keyAddr;

  int nChecks = 0;
  int nFail   = 0;
  logic [31:0] ptArr [4];

  typedef struct {
    logic [3:0]  setMask;
    logic [3:0]  rekeyMask;
    logic [31:0] pt;
    logic [31:0] cipher;
    int          doneDelay;
    bit          preDone;
    bit          ackEn;
    logic [3:0]  expWinner;
    bit          expRekey;
  } vec_t;

  vec_t vecs [11];
  vec_t post [2];

  simon_req_sched #(
    .NUM_REQ(NUM_REQ), .KEY_BASE(KEY_BASE), .KEY_WORDS(KEY_WORDS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(reqValid), .req_rekey(reqRekey), .req_pt(reqPt),
    .req_ready(reqReady), .rsp_valid(rspValid), .rsp_data(rspData), .rsp_error(rspError),
    .busy(busy), .key_we(keyWe), .key_addr(keyAddr), .key_ack(keyAck),
    .cipher_en(cipherEn), .plaintext(plaintext), .cipher_out(cipherOut), .done(done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One transaction: raise requests, play the simonrngtop side, then compare.
  task automatic applyStimulus(input vec_t v, input int rowId);
    int cyc, grantCyc, enCyc, rspCyc, readyCnt, enCnt, rspCnt, nWr, keyWeCyc, cd;
    int expWrites, winIdx;
    logic [3:0] readyVal, rspVal;
    logic [31:0] enPt, rspD;
    logic rspErr, busyAtGrant, busyAtRsp, busyAfter, keyWeAtRsp, waiting;
    logic [8:0] wrAddr [4];
    int wrCyc [4];
    string tag;
    tag = $sformatf("row%0d", rowId);
    grantCyc = -1; enCyc = -1; rspCyc = -1; readyCnt = 0; enCnt = 0; rspCnt = 0;
    nWr = 0; keyWeCyc = 0; cd = 0; waiting = 1'b0; readyVal = '0; rspVal = '0;
    enPt = '0; rspD = '0; rspErr = 1'b0; busyAtGrant = 1'b0; busyAtRsp = 1'b0;
    busyAfter = 1'b1; keyWeAtRsp = 1'b1;
    for (int k = 0; k < 4; k++) begin wrAddr[k] = '0; wrCyc[k] = 0; end
    for (int i = 0; i < 4; i++) begin
      if (v.setMask[i]) begin
        reqValid[i] = 1'b1;
        ptArr[i] = v.pt ^ (32'(i) << 28);
        reqPt[32*i +: 32] = ptArr[i];
      end
    end
    reqRekey = v.rekeyMask;
    winIdx = 0;
    for (int i = 0; i < 4; i++) if (v.expWinner[i]) winIdx = i;
    for (cyc = 1; cyc <= TIMEOUT + 64; cyc++) begin
      @(negedge clk);
      if (reqReady != 4'b0) begin
        readyCnt++; grantCyc = cyc; readyVal = reqReady; busyAtGrant = busy;
        reqValid = reqValid & ~reqReady;
      end
      if (keyWe) begin
        keyWeCyc++;
        if (v.ackEn) begin
          if (nWr < 4) begin wrAddr[nWr] = keyAddr; wrCyc[nWr] = cyc; end
          nWr++;
          keyAck = 1'b1;
        end else keyAck = 1'b0;
      end else keyAck = 1'b0;
      if (cipherEn) begin
        enCnt++; enCyc = cyc; enPt = plaintext; cd = v.doneDelay; waiting = 1'b1;
        done = v.preDone;
        cipherOut = v.preDone ? 32'hBAD0BAD0 : 32'h0;
      end else if (waiting) begin
        if (cd == 0) begin done = 1'b1; cipherOut = v.cipher; waiting = 1'b0; end
        else begin cd--; done = 1'b0; cipherOut = '0; end
      end else begin
        done = v.preDone && readyCnt > 0 && enCnt == 0;
        cipherOut = done ? 32'hBAD0BAD0 : 32'h0;
      end
      if (rspValid != 4'b0) begin
        rspCnt++; rspCyc = cyc; rspVal = rspValid; rspD = rspData; rspErr = rspError;
        busyAtRsp = busy; keyWeAtRsp = keyWe;
      end
      if (rspCnt > 0 && cyc == rspCyc + 1) begin
        busyAfter = busy;
        break;
      end
    end
    done = 1'b0; keyAck = 1'b0; cipherOut = '0;
    expWrites = (v.expRekey && v.ackEn) ? KEY_WORDS : 0;
    checkOutput({tag, " rspSeen"}, rspCnt, 1);
    checkOutput({tag, " grant"}, readyVal, v.expWinner);
    checkOutput({tag, " grantCnt"}, readyCnt, 1);
    checkOutput({tag, " busyGrant"}, busyAtGrant, 1);
    checkOutput({tag, " keyWrites"}, nWr, expWrites);
    checkOutput({tag, " keyWeCycles"}, keyWeCyc, v.ackEn ? expWrites : TIMEOUT);
    for (int k = 0; k < expWrites && k < nWr && k < 4; k++) begin
      checkOutput($sformatf("%s keyAddr%0d", tag, k), wrAddr[k], KEY_BASE + 9'(k));
      if (k > 0) checkOutput($sformatf("%s keyGap%0d", tag, k), wrCyc[k] - wrCyc[k-1], 2);
    end
    checkOutput({tag, " cipherEnCnt"}, enCnt, v.ackEn ? 1 : 0);
    if (v.ackEn) begin
      checkOutput({tag, " startLat"}, enCyc - grantCyc, 1 + 2 * expWrites);
      checkOutput({tag, " plaintext"}, enPt, ptArr[winIdx]);
      checkOutput({tag, " rspLat"}, rspCyc - enCyc, 2 + v.doneDelay);
      checkOutput({tag, " rspData"}, rspD, v.cipher);
      checkOutput({tag, " rspError"}, rspErr, 0);
    end else begin
      checkOutput({tag, " timeoutLat"}, rspCyc - grantCyc, TIMEOUT + 1);
      checkOutput({tag, " rspData"}, rspD, 0);
      checkOutput({tag, " rspError"}, rspErr, 1);
    end
    checkOutput({tag, " rspValid"}, rspVal, v.expWinner);
    checkOutput({tag, " busyRsp"}, busyAtRsp, 1);
    checkOutput({tag, " keyWeRsp"}, keyWeAtRsp, 0);
    checkOutput({tag, " busyAfter"}, busyAfter, 0);
  endtask

  initial begin
    bit seenEn;
    int rspSeen;
    reqValid = '0; reqRekey = '0; reqPt = '0; keyAck = 1'b0; done = 1'b0; cipherOut = '0;
    for (int i = 0; i < 4; i++) ptArr[i] = '0;
    //          set      rekey    pt            cipher        dly pre ack win      rekey
    vecs[0]  = '{4'b0001, 4'b0000, 32'hDEADBEEF, 32'hC0FFEE01, 3, 0, 1, 4'b0001, 1};
    vecs[1]  = '{4'b0001, 4'b0000, 32'h12345678, 32'hA5A50001, 0, 0, 1, 4'b0001, 0};
    vecs[2]  = '{4'b1000, 4'b0000, 32'h0BADCAFE, 32'h00000002, 1, 0, 1, 4'b1000, 0};
    vecs[3]  = '{4'b1111, 4'b0000, 32'h01010101, 32'h00000003, 2, 0, 1, 4'b0001, 0};
    vecs[4]  = '{4'b0000, 4'b0000, 32'h00000000, 32'h00000004, 0, 0, 1, 4'b0010, 0};
    vecs[5]  = '{4'b0001, 4'b0000, 32'h77777777, 32'h00000005, 1, 0, 1, 4'b0100, 0};
    vecs[6]  = '{4'b0000, 4'b0000, 32'h00000000, 32'h00000006, 0, 0, 1, 4'b1000, 0};
    vecs[7]  = '{4'b0000, 4'b0000, 32'h00000000, 32'h00000007, 4, 0, 1, 4'b0001, 0};
    vecs[8]  = '{4'b0100, 4'b0100, 32'h5A5A5A5A, 32'h00000008, 2, 1, 1, 4'b0100, 1};
    vecs[9]  = '{4'b0010, 4'b0010, 32'h99999999, 32'h00000009, 0, 0, 0, 4'b0010, 1};
    vecs[10] = '{4'b0001, 4'b0000, 32'h31415926, 32'h2718281A, 1, 0, 1, 4'b0001, 1};
    post[0]  = '{4'b1010, 4'b0000, 32'h2468ACE0, 32'h00000011, 1, 0, 1, 4'b0010, 1};
    post[1]  = '{4'b0000, 4'b0000, 32'h00000000, 32'h00000012, 0, 0, 1, 4'b1000, 0};

    @(negedge clk);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstReady", reqReady, 0);
    checkOutput("rstRspValid", rspValid, 0);
    checkOutput("rstKeyWe", keyWe, 0);
    checkOutput("rstCipherEn", cipherEn, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int r = 0; r < 11; r++) applyStimulus(vecs[r], r);

    // Reset while the cipher is running: outputs clear at once, no response follows.
    reqValid[2] = 1'b1;
    ptArr[2] = 32'hFEEDF00D;
    reqPt[64 +: 32] = ptArr[2];
    reqRekey = '0;
    seenEn = 1'b0;
    for (int c = 0; c < 40 && !seenEn; c++) begin
      @(negedge clk);
      if (reqReady != 4'b0) reqValid = reqValid & ~reqReady;
      keyAck = keyWe;
      if (cipherEn) seenEn = 1'b1;
    end
    keyAck = 1'b0;
    checkOutput("abortReachStart", 32'(seenEn), 1);
    @(negedge clk);
    checkOutput("abortBusyPre", busy, 1);
    checkOutput("abortPtPre", plaintext, 32'hFEEDF00D);
    rst = 1'b1;
    #1;
    checkOutput("abortBusy", busy, 0);
    checkOutput("abortPt", plaintext, 0);
    checkOutput("abortKeyAddr", 32'(keyAddr), 0);
    checkOutput("abortRspValid", rspValid, 0);
    checkOutput("abortRspData", rspData, 0);
    checkOutput("abortCipherEn", cipherEn, 0);
    done = 1'b1;
    cipherOut = 32'h13572468;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    done = 1'b0;
    cipherOut = '0;
    rspSeen = 0;
    repeat (4) begin
      @(negedge clk);
      if (rspValid != 4'b0 || busy) rspSeen++;
    end
    checkOutput("abortQuiet", rspSeen, 0);

    for (int r = 0; r < 2; r++) applyStimulus(post[r], 11 + r);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
